mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single memory-simulator port between the instruction-fetch cache
//   and the data (MEM) cache. It holds one transaction in flight at a time.
//   Each cache refill or write-through is forwarded to memory, and the response
//   is routed back to the cache that owns the transaction. Sits between
//   if_cache/mem_cache and mem_sim in the minimal SoC.
// PARAMETERS
//   PRIORITY   0      0 = round-robin between IF and MEM; 1 = MEM fixed priority
//   TIMEOUT    64     cycles in WAIT with no response before the request is re-issued; 0 disables
// PORTS
//   clk               in   1   clock
//   rst               in   1   synchronous reset, active high
//   if_req_i          in   1   IF cache request, level, held until if_rep_o
//   if_addr_i         in   32  IF line address
//   if_rep_o          out  1   one-cycle response pulse to IF cache
//   if_rep_data_o     out  64  line data returned to IF cache
//   mem_req_i         in   1   MEM cache request, level, held until mem_rep_o
//   mem_addr_i        in   32  MEM address
//   mem_write_i       in   1   1 = write, 0 = line read
//   mem_write_data_i  in   32  write data
//   mem_write_mask_i  in   4   byte enables for the write
//   mem_rep_o         out  1   one-cycle response pulse to MEM cache
//   mem_rep_data_o    out  64  line data returned to MEM cache
//   ms_req_o          out  1   one-cycle request pulse to mem_sim
//   ms_addr_o         out  32  latched address
//   ms_write_o        out  1   latched write flag (always 0 for IF)
//   ms_write_data_o   out  32  latched write data
//   ms_write_mask_o   out  4   latched byte mask
//   ms_rep_i          in   1   mem_sim response pulse
//   ms_rep_data_i     in   64  mem_sim response data
//   busy_o            out  1   1 in every state except IDLE
//   timeout_o         out  1   sticky; set on the first re-issue, cleared only by rst
// BEHAVIOUR
//   - All outputs are registered and are 0 at reset. State = IDLE, last_owner = IF
//     (so MEM wins the first tie), timer = 0.
//   - States: IDLE -> ISSUE -> WAIT -> RESP -> GAP -> IDLE.
//   - IDLE: if any request is present, pick the owner and latch its addr/write/data/mask.
//     The latch is frozen for the rest of the transaction.
//     - Sole requester wins.
//     - Tie: PRIORITY=1 gives MEM; PRIORITY=0 gives the requester that is not last_owner.
//     - Go to ISSUE. No request: stay in IDLE.
//   - ISSUE: ms_req_o=1 for exactly this cycle, with the latched fields on the ms_* outputs.
//     ms_* fields stay stable until the state leaves WAIT. Clear timer; go to WAIT.
//   - WAIT: the timer counts up by 1 per cycle.
//     - ms_rep_i=1: capture ms_rep_data_i, set last_owner = owner, go to RESP.
//     - Timer reaches TIMEOUT-1 with no response (TIMEOUT != 0): set timeout_o, go back
//       to ISSUE with the same latched fields.
//     - ms_rep_i in the same cycle as expiry: the response wins and there is no re-issue.
//   - RESP: owner's rep_o=1 and rep_data_o = captured data for one cycle. The
//     non-owner's rep_o stays 0. Go to GAP.
//   - GAP: one dead cycle with no grant, so the owner can drop its request; then IDLE.
//   - Latency: grant cycle T in IDLE; ms_req_o at T+1; response at R; rep_o at R+1;
//     next possible grant at R+3.
//   - rep_data_o holds its last value when rep_o=0. Writes also get a rep pulse,
//     and its data is don't-care.
//   - ms_rep_i outside WAIT is ignored.
//   - A requester dropping req mid-transaction does not abort it; rep_o is still pulsed.
//   - rst in any state returns to the reset values at the next edge. A late memory
//     response after reset is ignored because the state is IDLE.
// TESTING
//   - IF-only read: if_req_i=1, addr=0x100; mem replies 3 cycles after ms_req_o with
//     0xDEADBEEF_CAFEF00D -> one ms_req_o pulse with addr 0x100, write=0; one if_rep_o
//     pulse carrying that data; mem_rep_o stays 0.
//   - Simultaneous requests after reset (IF 0x200, MEM write 0x300, data 0x12345678,
//     mask 0xF), PRIORITY=0 -> MEM is served first, then IF. Repeat the tie -> IF is
//     served first.
//   - PRIORITY=1 with both requesters held constantly -> MEM always wins; IF is served
//     only when mem_req_i=0.
//   - TIMEOUT=8 and mem drops the first request -> ms_req_o pulses again 8 cycles after
//     the first, with the same fields; timeout_o=1; the later response is routed correctly.
//   - Stray ms_rep_i in IDLE -> no rep pulse. Response coincident with timer expiry ->
//     rep pulse and no re-issue.
//   - rst asserted during WAIT, then ms_rep_i arrives -> all outputs 0, state IDLE, no
//     rep pulse; the next request is handled normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets the instruction-fetch cache and the data cache share the one mem_sim port.
// Only one transaction is in flight at a time. Each response goes back to the cache
// that owns the transaction. A transaction that gets no response is re-issued after
// a programmable number of cycles.
module mem_port_arbiter #(
  parameter int unsigned PRIORITY = 0,   // 0: round-robin, 1: MEM fixed priority
  parameter int unsigned TIMEOUT  = 64   // WAIT cycles before re-issue, 0 disables
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction-fetch cache
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rep_o,
  output logic [63:0] if_rep_data_o,
  // Data cache
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_write_i,
  input  logic [31:0] mem_write_data_i,
  input  logic [3:0]  mem_write_mask_i,
  output logic        mem_rep_o,
  output logic [63:0] mem_rep_data_o,
  // Memory simulator
  output logic        ms_req_o,
  output logic [31:0] ms_addr_o,
  output logic        ms_write_o,
  output logic [31:0] ms_write_data_o,
  output logic [3:0]  ms_write_mask_o,
  input  logic        ms_rep_i,
  input  logic [63:0] ms_rep_data_i,
  // Status
  output logic        busy_o,
  output logic        timeout_o
);

  // The timer only has to reach TIMEOUT-2 before the expiry check fires.
  localparam int unsigned TimerW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StGap} state_e;

  state_e state_q, state_d;

  // Transaction latch. Owner encoding: 1 = MEM, 0 = IF.
  logic              owner_q;
  logic              last_owner_q;
  logic [TimerW-1:0] timer_q;
  logic [31:0]       addr_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic [3:0]        mask_q;

  // Registered outputs
  logic        ms_req_q, ms_req_d;
  logic        if_rep_q, if_rep_d;
  logic        mem_rep_q, mem_rep_d;
  logic [63:0] if_rep_data_q, if_rep_data_d;
  logic [63:0] mem_rep_data_q, mem_rep_data_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;

  logic any_req;
  logic grant_mem;
  logic rep_seen;
  logic expire;

  assign any_req = if_req_i | mem_req_i;

  // MEM wins when it is alone, or when there is a tie and MEM has priority or IF went last.
  assign grant_mem = mem_req_i & (~if_req_i | (PRIORITY != 0) | ~last_owner_q);

  assign rep_seen = (state_q == StWait) & ms_rep_i;

  // The timer value after this cycle's increment has reached TIMEOUT-1.
  assign expire = (TIMEOUT != 0) && ((32'(timer_q) + 32'd1) >= (TIMEOUT - 32'd1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A response beats a timer expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (ms_rep_i) begin
          state_d = StResp;
        end else if (expire) begin
          state_d = StIssue;
        end
      end
      StResp:  state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output next values. Each output is registered from the state being entered.
  always_comb begin
    ms_req_d       = (state_d == StIssue);
    busy_d         = (state_d != StIdle);
    timeout_d      = timeout_q | ((state_q == StWait) & (state_d == StIssue));
    if_rep_d       = (state_d == StResp) & ~owner_q;
    mem_rep_d      = (state_d == StResp) & owner_q;
    if_rep_data_d  = if_rep_data_q;
    mem_rep_data_d = mem_rep_data_q;
    if (rep_seen) begin
      if (owner_q) begin
        mem_rep_data_d = ms_rep_data_i;
      end else begin
        if_rep_data_d = ms_rep_data_i;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_req_q       <= 1'b0;
      if_rep_q       <= 1'b0;
      mem_rep_q      <= 1'b0;
      if_rep_data_q  <= '0;
      mem_rep_data_q <= '0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      ms_req_q       <= ms_req_d;
      if_rep_q       <= if_rep_d;
      mem_rep_q      <= mem_rep_d;
      if_rep_data_q  <= if_rep_data_d;
      mem_rep_data_q <= mem_rep_data_d;
      busy_q         <= busy_d;
      timeout_q      <= timeout_d;
    end
  end

  // Transaction latch, WAIT timer and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      timer_q      <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      mask_q       <= '0;
    end else begin
      // Fields are captured only at the grant and stay frozen until the next grant.
      if ((state_q == StIdle) && any_req) begin
        owner_q <= grant_mem;
        addr_q  <= grant_mem ? mem_addr_i : if_addr_i;
        write_q <= grant_mem & mem_write_i;
        wdata_q <= grant_mem ? mem_write_data_i : '0;
        mask_q  <= grant_mem ? mem_write_mask_i : '0;
      end
      if (state_q == StIssue) begin
        timer_q <= '0;
      end else if ((state_q == StWait) && (TIMEOUT != 0)) begin
        timer_q <= timer_q + 1'b1;
      end
      if (rep_seen) begin
        last_owner_q <= owner_q;
      end
    end
  end

  assign ms_req_o        = ms_req_q;
  assign ms_addr_o       = addr_q;
  assign ms_write_o      = write_q;
  assign ms_write_data_o = wdata_q;
  assign ms_write_mask_o = mask_q;
  assign if_rep_o        = if_rep_q;
  assign if_rep_data_o   = if_rep_data_q;
  assign mem_rep_o       = mem_rep_q;
  assign mem_rep_data_o  = mem_rep_data_q;
  assign busy_o          = busy_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. DUT A is round-robin with an 8-cycle timeout.
// DUT B has MEM fixed priority and the timeout disabled.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared request fields
  logic [31:0] if_addr     = '0;
  logic [31:0] mem_addr    = '0;
  logic        mem_write   = 1'b0;
  logic [31:0] mem_wdata   = '0;
  logic [3:0]  mem_mask    = '0;
  logic [63:0] ms_rep_data = '0;

  // Per-DUT handshakes
  logic if_req_a = 1'b0, mem_req_a = 1'b0, ms_rep_a = 1'b0;
  logic if_req_b = 1'b0, mem_req_b = 1'b0, ms_rep_b = 1'b0;

  logic        a_if_rep, a_mem_rep, a_ms_req, a_ms_write, a_busy, a_timeout;
  logic [63:0] a_if_rep_data, a_mem_rep_data;
  logic [31:0] a_ms_addr, a_ms_wdata;
  logic [3:0]  a_ms_mask;
  logic        b_if_rep, b_mem_rep, b_ms_req, b_ms_write, b_busy, b_timeout;
  logic [63:0] b_if_rep_data, b_mem_rep_data;
  logic [31:0] b_ms_addr, b_ms_wdata;
  logic [3:0]  b_ms_mask;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.PRIORITY(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_a), .if_addr_i(if_addr), .if_rep_o(a_if_rep), .if_rep_data_o(a_if_rep_data),
    .mem_req_i(mem_req_a), .mem_addr_i(mem_addr), .mem_write_i(mem_write),
    .mem_write_data_i(mem_wdata), .mem_write_mask_i(mem_mask),
    .mem_rep_o(a_mem_rep), .mem_rep_data_o(a_mem_rep_data),
    .ms_req_o(a_ms_req), .ms_addr_o(a_ms_addr), .ms_write_o(a_ms_write),
    .ms_write_data_o(a_ms_wdata), .ms_write_mask_o(a_ms_mask),
    .ms_rep_i(ms_rep_a), .ms_rep_data_i(ms_rep_data),
    .busy_o(a_busy), .timeout_o(a_timeout)
  );

  mem_port_arbiter #(.PRIORITY(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_b), .if_addr_i(if_addr), .if_rep_o(b_if_rep), .if_rep_data_o(b_if_rep_data),
    .mem_req_i(mem_req_b), .mem_addr_i(mem_addr), .mem_write_i(mem_write),
    .mem_write_data_i(mem_wdata), .mem_write_mask_i(mem_mask),
    .mem_rep_o(b_mem_rep), .mem_rep_data_o(b_mem_rep_data),
    .ms_req_o(b_ms_req), .ms_addr_o(b_ms_addr), .ms_write_o(b_ms_write),
    .ms_write_data_o(b_ms_wdata), .ms_write_mask_o(b_ms_mask),
    .ms_rep_i(ms_rep_b), .ms_rep_data_i(ms_rep_data),
    .busy_o(b_busy), .timeout_o(b_timeout)
  );

  // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Wait 'delay' cycles, then pulse the response for one cycle. Returns at the RESP cycle.
  task automatic respond(input bit sel_b, input int delay, input logic [63:0] data);
    for (int i = 0; i < delay; i++) tick();
    ms_rep_data = data;
    if (sel_b) ms_rep_b = 1'b1;
    else       ms_rep_a = 1'b1;
    tick();
    ms_rep_a = 1'b0;
    ms_rep_b = 1'b0;
  endtask

  task automatic test_reset();
    logic [201:0] va, vb;
    rst = 1'b1;
    tick();
    tick();
    va = {a_if_rep, a_if_rep_data, a_mem_rep, a_mem_rep_data, a_ms_req, a_ms_addr, a_ms_write,
          a_ms_wdata, a_ms_mask, a_busy, a_timeout};
    vb = {b_if_rep, b_if_rep_data, b_mem_rep, b_mem_rep_data, b_ms_req, b_ms_addr, b_ms_write,
          b_ms_wdata, b_ms_mask, b_busy, b_timeout};
    checks++;
    if (va !== '0) begin
      failures++;
      $display("FAIL reset_outputs_a: got %h want 0", va);
    end
    checks++;
    if (vb !== '0) begin
      failures++;
      $display("FAIL reset_outputs_b: got %h want 0", vb);
    end
    rst = 1'b0;
  endtask

  task automatic test_if_read();
    if_addr  = 32'h100;
    if_req_a = 1'b1;
    tick();  // ISSUE
    checks++;
    if ({a_ms_req, a_ms_addr, a_ms_write, a_busy} !== {1'b1, 32'h100, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL if_read_issue: got req=%0b addr=%h wr=%0b busy=%0b want 1 100 0 1",
               a_ms_req, a_ms_addr, a_ms_write, a_busy);
    end
    tick();
    checks++;
    if (a_ms_req !== 1'b0) begin
      failures++;
      $display("FAIL if_read_single_pulse: got ms_req=%0b want 0", a_ms_req);
    end
    respond(1'b0, 2, 64'hDEADBEEF_CAFEF00D);  // three cycles after ms_req_o
    checks++;
    if ({a_if_rep, a_mem_rep, a_if_rep_data} !== {1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D}) begin
      failures++;
      $display("FAIL if_read_rep: got if=%0b mem=%0b data=%h want 1 0 deadbeefcafef00d",
               a_if_rep, a_mem_rep, a_if_rep_data);
    end
    if_req_a = 1'b0;
    tick();  // GAP
    checks++;
    if ({a_if_rep, a_if_rep_data} !== {1'b0, 64'hDEADBEEF_CAFEF00D}) begin
      failures++;
      $display("FAIL if_read_hold: got rep=%0b data=%h want 0 deadbeefcafef00d",
               a_if_rep, a_if_rep_data);
    end
    tick();  // IDLE
    checks++;
    if (a_busy !== 1'b0) begin
      failures++;
      $display("FAIL if_read_idle: got busy=%0b want 0", a_busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    if_addr   = 32'h200;
    mem_addr  = 32'h300;
    mem_write = 1'b1;
    mem_wdata = 32'h12345678;
    mem_mask  = 4'hF;
    if_req_a  = 1'b1;
    mem_req_a = 1'b1;
    tick();  // first tie after reset goes to MEM
    checks++;
    if ({a_ms_addr, a_ms_write, a_ms_wdata, a_ms_mask} !== {32'h300, 1'b1, 32'h12345678, 4'hF})
    begin
      failures++;
      $display("FAIL rr_first_mem: got %h %0b %h %h want 300 1 12345678 f",
               a_ms_addr, a_ms_write, a_ms_wdata, a_ms_mask);
    end
    respond(1'b0, 1, 64'h1111);
    checks++;
    if ({a_mem_rep, a_if_rep} !== 2'b10) begin
      failures++;
      $display("FAIL rr_first_rep: got mem=%0b if=%0b want 1 0", a_mem_rep, a_if_rep);
    end
    tick();
    tick();  // IDLE at R+3
    checks++;
    if ({a_busy, a_ms_req} !== 2'b00) begin
      failures++;
      $display("FAIL rr_gap: got busy=%0b req=%0b want 0 0", a_busy, a_ms_req);
    end
    tick();  // repeated tie, MEM went last so IF wins
    checks++;
    if ({a_ms_req, a_ms_addr, a_ms_write, a_ms_wdata, a_ms_mask} !==
        {1'b1, 32'h200, 1'b0, 32'h0, 4'h0}) begin
      failures++;
      $display("FAIL rr_second_if: got req=%0b %h %0b %h %h want 1 200 0 0 0",
               a_ms_req, a_ms_addr, a_ms_write, a_ms_wdata, a_ms_mask);
    end
    respond(1'b0, 1, 64'h2222);
    checks++;
    if ({a_mem_rep, a_if_rep, a_if_rep_data, a_mem_rep_data} !==
        {2'b01, 64'h2222, 64'h1111}) begin
      failures++;
      $display("FAIL rr_second_rep: got mem=%0b if=%0b idata=%h mdata=%h want 0 1 2222 1111",
               a_mem_rep, a_if_rep, a_if_rep_data, a_mem_rep_data);
    end
    tick();
    tick();
    tick();  // third tie goes back to MEM
    checks++;
    if (a_ms_addr !== 32'h300) begin
      failures++;
      $display("FAIL rr_third_mem: got addr=%h want 300", a_ms_addr);
    end
    respond(1'b0, 1, 64'h3333);
    if_req_a  = 1'b0;
    mem_req_a = 1'b0;
    mem_write = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_priority();
    logic seen;
    do_reset();
    if_addr   = 32'h200;
    mem_addr  = 32'h300;
    mem_write = 1'b0;
    if_req_b  = 1'b1;
    mem_req_b = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (b_ms_addr !== 32'h300) begin
        failures++;
        $display("FAIL prio_mem_grant_%0d: got addr=%h want 300", r, b_ms_addr);
      end
      respond(1'b1, 1, 64'h5000 + 64'(r));
      checks++;
      if ({b_mem_rep, b_if_rep} !== 2'b10) begin
        failures++;
        $display("FAIL prio_mem_rep_%0d: got mem=%0b if=%0b want 1 0", r, b_mem_rep, b_if_rep);
      end
      if (r == 2) mem_req_b = 1'b0;
      tick();
      tick();
      tick();
    end
    checks++;
    if ({b_ms_req, b_ms_addr} !== {1'b1, 32'h200}) begin
      failures++;
      $display("FAIL prio_if_grant: got req=%0b addr=%h want 1 200", b_ms_req, b_ms_addr);
    end
    // Timeout disabled: a long silence must not re-issue.
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | b_ms_req;
    end
    checks++;
    if ({seen, b_timeout, b_busy} !== 3'b001) begin
      failures++;
      $display("FAIL prio_no_timeout: got reissue=%0b timeout=%0b busy=%0b want 0 0 1",
               seen, b_timeout, b_busy);
    end
    respond(1'b1, 0, 64'hBEEF);
    checks++;
    if ({b_if_rep, b_mem_rep, b_if_rep_data} !== {2'b10, 64'hBEEF}) begin
      failures++;
      $display("FAIL prio_if_rep: got if=%0b mem=%0b data=%h want 1 0 beef",
               b_if_rep, b_mem_rep, b_if_rep_data);
    end
    if_req_b = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic seen;
    do_reset();
    mem_addr  = 32'h300;
    mem_write = 1'b1;
    mem_wdata = 32'h12345678;
    mem_mask  = 4'h3;
    mem_req_a = 1'b1;
    tick();  // first ISSUE
    checks++;
    if (a_ms_req !== 1'b1) begin
      failures++;
      $display("FAIL to_first_issue: got req=%0b want 1", a_ms_req);
    end
    // Inputs change mid-transaction; the latch must not follow them.
    mem_addr  = 32'hABC;
    mem_wdata = 32'h0;
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen = seen | a_ms_req;
    end
    checks++;
    if ({seen, a_timeout} !== 2'b00) begin
      failures++;
      $display("FAIL to_early: got reissue=%0b timeout=%0b want 0 0", seen, a_timeout);
    end
    tick();  // eight cycles after the first pulse
    checks++;
    if ({a_ms_req, a_timeout, a_ms_addr, a_ms_write, a_ms_wdata, a_ms_mask} !==
        {2'b11, 32'h300, 1'b1, 32'h12345678, 4'h3}) begin
      failures++;
      $display("FAIL to_reissue: got req=%0b to=%0b %h %0b %h %h want 1 1 300 1 12345678 3",
               a_ms_req, a_timeout, a_ms_addr, a_ms_write, a_ms_wdata, a_ms_mask);
    end
    respond(1'b0, 2, 64'h01234567_89ABCDEF);
    checks++;
    if ({a_mem_rep, a_if_rep, a_mem_rep_data} !== {2'b10, 64'h01234567_89ABCDEF}) begin
      failures++;
      $display("FAIL to_rep: got mem=%0b if=%0b data=%h want 1 0 0123456789abcdef",
               a_mem_rep, a_if_rep, a_mem_rep_data);
    end
    mem_req_a = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h300;
    tick();
    tick();
  endtask

  task automatic test_stray_and_coincident();
    ms_rep_a = 1'b1;
    tick();
    tick();
    ms_rep_a = 1'b0;
    checks++;
    if ({a_if_rep, a_mem_rep, a_busy, a_ms_req} !== 4'b0000) begin
      failures++;
      $display("FAIL stray_rep: got if=%0b mem=%0b busy=%0b req=%0b want 0 0 0 0",
               a_if_rep, a_mem_rep, a_busy, a_ms_req);
    end
    if_addr  = 32'h180;
    if_req_a = 1'b1;
    tick();  // ISSUE at I
    for (int i = 0; i < 6; i++) tick();
    respond(1'b0, 1, 64'hA5A5_5A5A_A5A5_5A5A);  // response in the expiry cycle I+7
    checks++;
    if ({a_if_rep, a_ms_req, a_if_rep_data} !== {2'b10, 64'hA5A5_5A5A_A5A5_5A5A}) begin
      failures++;
      $display("FAIL coincident_rep: got rep=%0b req=%0b data=%h want 1 0 a5a55a5aa5a55a5a",
               a_if_rep, a_ms_req, a_if_rep_data);
    end
    if_req_a = 1'b0;
    tick();
    checks++;
    if ({a_ms_req, a_busy, a_timeout} !== 3'b011) begin
      failures++;
      $display("FAIL coincident_gap: got req=%0b busy=%0b timeout=%0b want 0 1 1",
               a_ms_req, a_busy, a_timeout);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    logic [201:0] va;
    if_addr  = 32'h100;
    if_req_a = 1'b1;
    tick();
    tick();
    tick();  // WAIT
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    if_req_a    = 1'b0;
    ms_rep_a    = 1'b1;  // late response arriving in IDLE
    ms_rep_data = 64'hFFFF_0000_FFFF_0000;
    tick();
    ms_rep_a = 1'b0;
    va = {a_if_rep, a_if_rep_data, a_mem_rep, a_mem_rep_data, a_ms_req, a_ms_addr, a_ms_write,
          a_ms_wdata, a_ms_mask, a_busy, a_timeout};
    checks++;
    if (va !== '0) begin
      failures++;
      $display("FAIL rst_wait_outputs: got %h want 0", va);
    end
    tick();
    checks++;
    if ({a_if_rep, a_busy} !== 2'b00) begin
      failures++;
      $display("FAIL rst_wait_late_rep: got rep=%0b busy=%0b want 0 0", a_if_rep, a_busy);
    end
    if_addr  = 32'h140;
    if_req_a = 1'b1;
    tick();
    checks++;
    if ({a_ms_req, a_ms_addr} !== {1'b1, 32'h140}) begin
      failures++;
      $display("FAIL rst_wait_next_issue: got req=%0b addr=%h want 1 140", a_ms_req, a_ms_addr);
    end
    respond(1'b0, 1, 64'h7777);
    checks++;
    if ({a_if_rep, a_if_rep_data} !== {1'b1, 64'h7777}) begin
      failures++;
      $display("FAIL rst_wait_next_rep: got rep=%0b data=%h want 1 7777", a_if_rep, a_if_rep_data);
    end
    if_req_a = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_round_robin();
    test_priority();
    test_timeout();
    test_stray_and_coincident();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
